// File: rtl/traffic_pkg.sv
// Shared constants for the 4-way traffic controller request path.
package traffic_pkg;

    localparam int unsigned NUM_LANES = 4;
    localparam int unsigned LANE_W    = 2;
    localparam int unsigned AGE_W     = 8;

    // LANE_W already names the index width, so west is spelled out.
    typedef enum logic [LANE_W-1:0] {
        LANE_N    = 2'd0,
        LANE_E    = 2'd1,
        LANE_S    = 2'd2,
        LANE_WEST = 2'd3
    } lane_e;

endpackage

// File: rtl/traffic_debounce.sv
// One lane of sensor conditioning: 2-FF synchronizer, debounce counter,
// accepted level and a registered pulse on each accepted 0->1 transition.
module traffic_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 50_000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena_i,
    input  logic sensor_i,
    output logic rise_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise_q, rise_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sensor_i;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        rise_d = level_d & ~level_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
        end else if (ena_i) begin
            level_q <= level_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
        end else begin
            rise_q  <= 1'b0;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/traffic_request_conditioner.sv
// Debounces lane sensors into sticky requests, ages pending lanes and
// nominates the longest-waiting one for the downstream arbiter.
module traffic_request_conditioner #(
    parameter int unsigned NUM_LANES       = traffic_pkg::NUM_LANES,
    parameter int unsigned DEBOUNCE_CYCLES = 50_000,
    parameter int unsigned CNT_W           = 16,
    parameter int unsigned AGE_W           = traffic_pkg::AGE_W
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           ena,
    input  logic [NUM_LANES-1:0]           sensor_in,
    input  logic                           age_tick,
    input  logic                           serve_valid,
    input  logic [traffic_pkg::LANE_W-1:0] serve_lane,
    output logic [NUM_LANES-1:0]           req_pending,
    output logic [NUM_LANES-1:0]           req_rise,
    output logic                           req_any,
    output logic                           oldest_valid,
    output logic [traffic_pkg::LANE_W-1:0] oldest_lane
);

    localparam int unsigned LW = traffic_pkg::LANE_W;

    logic [NUM_LANES-1:0] rise_w;
    logic [NUM_LANES-1:0] pend_q, pend_d;
    logic [NUM_LANES-1:0] rise_q;
    logic [AGE_W-1:0]     age_q [NUM_LANES];
    logic [AGE_W-1:0]     age_d [NUM_LANES];
    logic                 oldest_valid_q, oldest_valid_d;
    logic [LW-1:0]        oldest_lane_q, oldest_lane_d;
    logic [AGE_W-1:0]     best_age;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        traffic_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_debounce (
            .clk     (clk),
            .rst_n   (rst_n),
            .ena_i   (ena),
            .sensor_i(sensor_in[g]),
            .rise_o  (rise_w[g])
        );
    end

    // An accepted rise outranks a same-cycle serve: the lane stays pending with a fresh age.
    always_comb begin
        pend_d = pend_q;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            age_d[i] = age_q[i];
            if (rise_w[i]) begin
                pend_d[i] = 1'b1;
                age_d[i]  = '0;
            end else if (serve_valid && serve_lane == LW'(i)) begin
                pend_d[i] = 1'b0;
                age_d[i]  = '0;
            end else if (!pend_q[i]) begin
                age_d[i]  = '0;
            end else if (age_tick && age_q[i] != '1) begin
                age_d[i]  = age_q[i] + AGE_W'(1);
            end
        end
    end

    always_comb begin
        oldest_valid_d = 1'b0;
        oldest_lane_d  = '0;
        best_age       = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (pend_q[i] && (!oldest_valid_d || age_q[i] > best_age)) begin
                oldest_valid_d = 1'b1;
                oldest_lane_d  = LW'(i);
                best_age       = age_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q         <= '0;
            rise_q         <= '0;
            age_q          <= '{default: '0};
            oldest_valid_q <= 1'b0;
            oldest_lane_q  <= '0;
        end else if (ena) begin
            pend_q         <= pend_d;
            rise_q         <= rise_w;
            age_q          <= age_d;
            oldest_valid_q <= oldest_valid_d;
            oldest_lane_q  <= oldest_lane_d;
        end else begin
            rise_q         <= '0;
        end
    end

    assign req_pending  = pend_q;
    assign req_rise     = rise_q & {NUM_LANES{ena}};
    assign req_any      = |pend_q;
    assign oldest_valid = oldest_valid_q;
    assign oldest_lane  = oldest_lane_q;

endmodule

// File: tb/tb_traffic_request_conditioner.sv
// Directed scoreboard bench for traffic_request_conditioner with DEBOUNCE_CYCLES=4.
module tb_traffic_request_conditioner;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [3:0] sensor_in;
    logic       age_tick;
    logic       serve_valid;
    logic [1:0] serve_lane;
    logic [3:0] req_pending;
    logic [3:0] req_rise;
    logic       req_any;
    logic       oldest_valid;
    logic [1:0] oldest_lane;

    traffic_request_conditioner #(
        .NUM_LANES      (4),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (16),
        .AGE_W          (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .sensor_in   (sensor_in),
        .age_tick    (age_tick),
        .serve_valid (serve_valid),
        .serve_lane  (serve_lane),
        .req_pending (req_pending),
        .req_rise    (req_rise),
        .req_any     (req_any),
        .oldest_valid(oldest_valid),
        .oldest_lane (oldest_lane)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        string      name;
        logic [3:0] pend;
        logic       ov;
        logic [1:0] ol;
    } chk_t;

    typedef struct {
        int         at;
        logic [3:0] val;
    } rise_t;

    chk_t  chk_q [$];
    rise_t rq    [$];
    int    n_assert = 0;
    int    n_fail   = 0;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic exp_state(input int at, input string nm, input logic [3:0] p,
                             input logic ov, input logic [1:0] ol);
        chk_t c;
        c.at = at; c.name = nm; c.pend = p; c.ov = ov; c.ol = ol;
        chk_q.push_back(c);
    endtask

    task automatic exp_rise(input int at, input logic [3:0] v);
        rise_t r;
        r.at = at; r.val = v;
        rq.push_back(r);
    endtask

    // Monitor: compares DUT outputs against queued expectations on the falling edge.
    chk_t       cur;
    rise_t      rcur;
    logic [3:0] rise_exp;
    always @(negedge clk) begin
        while (chk_q.size() > 0 && chk_q[0].at < cyc) begin
            cur = chk_q.pop_front();
            n_assert++;
            n_fail++;
            $display("FAIL %s: check for cycle %0d not reached, now cycle %0d", cur.name, cur.at, cyc);
        end
        while (chk_q.size() > 0 && chk_q[0].at == cyc) begin
            cur = chk_q.pop_front();
            n_assert++;
            if (req_pending !== cur.pend || req_any !== (|cur.pend) ||
                oldest_valid !== cur.ov || oldest_lane !== cur.ol) begin
                n_fail++;
                $display("FAIL %s @%0d: pending=%b any=%b ov=%b ol=%0d, required pending=%b any=%b ov=%b ol=%0d",
                         cur.name, cyc, req_pending, req_any, oldest_valid, oldest_lane,
                         cur.pend, |cur.pend, cur.ov, cur.ol);
            end
        end
        rise_exp = '0;
        if (rq.size() > 0 && rq[0].at == cyc) begin
            rcur     = rq.pop_front();
            rise_exp = rcur.val;
        end
        if (req_rise !== 4'b0000 || rise_exp != 4'b0000) begin
            n_assert++;
            if (req_rise !== rise_exp) begin
                n_fail++;
                $display("FAIL req_rise @%0d: got %b, required %b", cyc, req_rise, rise_exp);
            end
        end
    end

    int base;

    initial begin
        rst_n       = 1'b0;
        ena         = 1'b1;
        sensor_in   = 4'b0000;
        age_tick    = 1'b0;
        serve_valid = 1'b0;
        serve_lane  = 2'd0;

        step(1);
        exp_state(cyc, "reset", 4'b0000, 1'b0, 2'd0);
        step(1);
        rst_n = 1'b1;
        step(2);

        // 1: held sensor accepted 6 cycles after first sampling edge
        base = cyc;
        sensor_in = 4'b0001;
        exp_state(base + 6, "t1_not_yet", 4'b0000, 1'b0, 2'd0);
        exp_rise (base + 7, 4'b0001);
        exp_state(base + 7, "t1_pending", 4'b0001, 1'b0, 2'd0);
        exp_state(base + 8, "t1_oldest", 4'b0001, 1'b1, 2'd0);
        step(8);

        // 2: 3-cycle glitches on lane 2 are rejected
        repeat (3) begin
            sensor_in[2] = 1'b1;
            step(3);
            sensor_in[2] = 1'b0;
            step(3);
        end
        step(6);
        exp_state(cyc, "t2_glitch", 4'b0001, 1'b1, 2'd0);
        step(1);

        // 3: serve lane 1, then serve idle lane 3
        base = cyc;
        sensor_in[1] = 1'b1;
        exp_rise (base + 7, 4'b0010);
        exp_state(base + 7, "t3_pending", 4'b0011, 1'b1, 2'd0);
        exp_state(base + 8, "t3_served", 4'b0001, 1'b1, 2'd0);
        exp_state(base + 9, "t3_idle_serve", 4'b0001, 1'b1, 2'd0);
        exp_state(base + 10, "t3_idle_oldest", 4'b0001, 1'b1, 2'd0);
        step(7);
        serve_valid = 1'b1; serve_lane = 2'd1;
        step(1);
        serve_lane = 2'd3;
        step(1);
        serve_valid = 1'b0;
        step(1);

        // 4: lane 0 aged 7, lane 3 aged 2
        age_tick = 1'b1;
        step(5);
        age_tick = 1'b0;
        base = cyc;
        sensor_in[3] = 1'b1;
        exp_rise (base + 7, 4'b1000);
        exp_state(base + 7, "t4_both", 4'b1001, 1'b1, 2'd0);
        exp_state(base + 10, "t4_oldest0", 4'b1001, 1'b1, 2'd0);
        exp_state(base + 11, "t4_serve_lag", 4'b1000, 1'b1, 2'd0);
        exp_state(base + 12, "t4_oldest3", 4'b1000, 1'b1, 2'd3);
        step(7);
        age_tick = 1'b1;
        step(2);
        age_tick = 1'b0;
        step(1);
        serve_valid = 1'b1; serve_lane = 2'd0;
        step(1);
        serve_valid = 1'b0;
        step(1);

        // 5: rise+serve on lane 2 restarts its age; saturation ties to lowest index
        base = cyc;
        sensor_in = 4'b0111;
        serve_valid = 1'b1; serve_lane = 2'd3;
        exp_state(base + 1, "t5_cleared", 4'b0000, 1'b1, 2'd3);
        exp_state(base + 2, "t5_none", 4'b0000, 1'b0, 2'd0);
        exp_rise (base + 7, 4'b0100);
        exp_state(base + 7, "t5_lane2", 4'b0100, 1'b0, 2'd0);
        exp_rise (base + 19, 4'b1000);
        exp_state(base + 19, "t5_lane3", 4'b1100, 1'b1, 2'd2);
        exp_state(base + 21, "t5_aged", 4'b1100, 1'b1, 2'd2);
        exp_rise (base + 33, 4'b0100);
        exp_state(base + 33, "t5_set_wins", 4'b1100, 1'b1, 2'd2);
        exp_state(base + 34, "t5_age_restart", 4'b1100, 1'b1, 2'd3);
        exp_state(base + 336, "t5_saturate", 4'b1100, 1'b1, 2'd2);
        exp_state(base + 343, "t5_stable", 4'b1100, 1'b1, 2'd2);
        step(1);
        serve_valid = 1'b0;
        step(6);
        age_tick = 1'b1;
        step(5);
        age_tick = 1'b0;
        sensor_in[3] = 1'b1;
        step(7);
        age_tick = 1'b1;
        step(1);
        age_tick = 1'b0;
        sensor_in[2] = 1'b0;
        step(6);
        sensor_in[2] = 1'b1;
        step(6);
        serve_valid = 1'b1; serve_lane = 2'd2;
        step(1);
        serve_valid = 1'b0;
        step(1);
        age_tick = 1'b1;
        step(300);
        age_tick = 1'b0;
        step(2);
        age_tick = 1'b1;
        step(5);
        age_tick = 1'b0;
        step(3);

        // 6: async reset mid-debounce with all lanes pending, then re-request
        base = cyc;
        sensor_in = 4'b1100;
        exp_rise (base + 13, 4'b0011);
        exp_state(base + 13, "t6_all_pending", 4'b1111, 1'b1, 2'd2);
        exp_state(base + 16, "t6_reset_now", 4'b0000, 1'b0, 2'd0);
        exp_state(base + 17, "t6_reset_hold", 4'b0000, 1'b0, 2'd0);
        exp_state(base + 24, "t6_requal_wait", 4'b0000, 1'b0, 2'd0);
        exp_rise (base + 25, 4'b1111);
        exp_state(base + 25, "t6_requal", 4'b1111, 1'b0, 2'd0);
        exp_state(base + 26, "t6_requal_old", 4'b1111, 1'b1, 2'd0);
        step(6);
        sensor_in = 4'b1111;
        step(7);
        sensor_in = 4'b1110;
        step(3);
        rst_n = 1'b0;
        sensor_in = 4'b1111;
        step(2);
        rst_n = 1'b1;
        step(8);

        // ena low: serve and tick ignored; then serve lane 0 normally
        base = cyc;
        ena = 1'b0;
        serve_valid = 1'b1; serve_lane = 2'd0;
        age_tick = 1'b1;
        exp_state(base + 1, "ena_hold", 4'b1111, 1'b1, 2'd0);
        exp_state(base + 2, "ena_serve", 4'b1110, 1'b1, 2'd0);
        exp_state(base + 3, "ena_oldest", 4'b1110, 1'b1, 2'd1);
        step(1);
        ena = 1'b1;
        age_tick = 1'b0;
        step(1);
        serve_valid = 1'b0;
        step(4);

        n_assert++;
        if (chk_q.size() != 0 || rq.size() != 0) begin
            n_fail++;
            $display("FAIL leftover: %0d state checks and %0d rise checks still queued, required 0",
                     chk_q.size(), rq.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
